ram_burst_sync: RTL and testbench
=================================

# ram_burst_sync

Parametrised synchronous single-port RAM with a burst command interface; the clocked successor to the asynchronous chip-select RAM. A requester issues one read or write command with a start address and beat count. The block then streams data beats with a valid/ready handshake on writes and fixed-latency valid on reads, wrapping the address at the top of memory. It sits between a bus master or DMA engine and on-chip storage, replacing the tri-state data bus with separate write and read data paths.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 5: address width; memory holds 2**DEPTH words.
- BURST_BITS, 2: width of LEN; bursts of 1..2**BURST_BITS beats.
- CLK  input  1  single clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ  input  1  command request.
- WE  input  1  command type, sampled with REQ: 1 = write burst, 0 = read burst.
- ADDR  input  DEPTH  burst start address, sampled with REQ.
- LEN  input  BURST_BITS  beats minus one, sampled with REQ.
- GNT  output  1  command can be accepted; combinational, = (state==IDLE) && !RST.
- WDATA  input  WIDTH  write beat data.
- WVALID  input  1  write beat valid.
- WREADY  output  1  write beat ready; high only in WRITE state.
- RDATA  output  WIDTH  read beat data, registered.
- RVALID  output  1  read beat valid, registered.
- BUSY  output  1  high when state is not IDLE.
- DONE  output  1  one-cycle pulse in the first IDLE cycle after a burst completes.

## Operation
- States: IDLE, WRITE, READ. Reset → IDLE.
- Accept: on an edge with state==IDLE and REQ=1.
  - ptr <= ADDR and cnt <= LEN.
  - State goes to WRITE if WE=1, otherwise READ.
  - ADDR, LEN and WE are ignored on all other edges.
- WRITE: WREADY=1.
  - On each edge with WVALID=1: MEM[ptr] <= WDATA, ptr <= ptr+1, cnt <= cnt-1.
  - WVALID=0 stalls with no write and no change to ptr or cnt.
  - On the beat with cnt==0: state → IDLE and DONE <= 1.
- READ: one beat per edge, no backpressure.
  - On each edge: RDATA <= MEM[ptr], RVALID <= 1, ptr <= ptr+1, cnt <= cnt-1.
  - On the beat with cnt==0: state → IDLE and DONE <= 1.
  - In every other state, RVALID <= 0.
- Address arithmetic is modulo 2**DEPTH: ptr at 2**DEPTH-1 wraps to 0 with no error.
- A burst longer than memory is impossible by parameter constraint: BURST_BITS ≤ DEPTH.
- RDATA holds its last value while RVALID=0.
- WDATA is ignored unless both WREADY and WVALID are 1.
- Memory contents are not reset and are undefined until written.
- Reset mid-burst:
  - The burst is aborted and the remaining beats are discarded.
  - Words already written are retained.
  - RVALID and DONE drop immediately.

## Timing
- Reset values: GNT=0 while RST=1; BUSY=0; WREADY=0; RVALID=0; RDATA=0; DONE=0; ptr=0; cnt=0.
- Write burst of N beats with WVALID held high:
  - N cycles in WRITE after the accept edge.
  - DONE is high in the cycle after the last beat edge.
- Read burst of N beats:
  - The first RVALID occurs in the second cycle after the accept edge (one-cycle RAM read).
  - RVALID is contiguous for N cycles.
  - DONE coincides with the last RVALID cycle, which is already an IDLE cycle.
- Back-to-back: GNT=1 in the DONE cycle, so a new command may be accepted on the next edge with zero idle gap.
- Read-after-write to the same address across bursts returns the new data.
- Within one burst there is no same-address hazard, since addresses are distinct.

## Test plan
- Write burst: ADDR=5, LEN=3, WDATA 0xA0..0xA3, WVALID held high, then read ADDR=5 LEN=3. Required: RVALID high 4 cycles with RDATA 0xA0,0xA1,0xA2,0xA3; DONE pulses once per burst.
- Wrap-around: write ADDR=30 LEN=3 with data 1,2,3,4, then read ADDR=0 LEN=1 and ADDR=30 LEN=1. Required: reads return 3,4 and 1,2.
- Write stall: ADDR=0 LEN=1, WVALID pattern 1,0,0,1. Required: only two writes occur; BUSY high for 4 cycles; DONE follows the fourth cycle; readback matches.
- Single beat and back-to-back: write LEN=0, with REQ for a read held during the DONE cycle. Required: the read is accepted on the next edge and returns the written word 2 cycles later.
- Reset mid-write: write ADDR=8 LEN=3, with RST asserted asynchronously after 2 beats. Required:
  - BUSY, WREADY and DONE go to 0 immediately.
  - Reading addresses 8..9 returns the written data.
  - Addresses 10..11 keep their prior contents.
- Reset values: RST held high with REQ=1. Required: GNT=0, no state change, and all outputs at their reset values; GNT=1 on the first cycle after RST releases.

Source files
------------

// File: rtl/ram_burst_sync.sv
// Synchronous single-port RAM with a burst command interface: one command
// (start address + beat count) followed by handshaked write beats or fixed-latency read beats.
module ram_burst_sync #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned BURST_BITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DEPTH-1:0]      addr_i,
    input  logic [BURST_BITS-1:0] len_i,
    output logic                  gnt_o,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned WORDS = 2 ** DEPTH;

    // A burst may never revisit an address, so it must fit in memory.
    if (BURST_BITS > DEPTH) begin : g_bad_params
        $error("ram_burst_sync: BURST_BITS must not exceed DEPTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e                state_q;
    logic [DEPTH-1:0]      ptr_q;
    logic [BURST_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]      rdata_q;
    logic                  rvalid_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  wready_q;
    logic [WIDTH-1:0]      mem_q [WORDS];
    logic                  wr_en_c;

    assign wr_en_c = (state_q == ST_WRITE) && wvalid_i;

    // Storage is deliberately left out of reset so contents survive an aborted burst.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            wready_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        ptr_q    <= addr_i;
                        cnt_q    <= len_i;
                        busy_q   <= 1'b1;
                        wready_q <= we_i;
                        state_q  <= we_i ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wvalid_i) begin
                        ptr_q <= ptr_q + DEPTH'(1);
                        cnt_q <= cnt_q - BURST_BITS'(1);
                        if (cnt_q == '0) begin
                            state_q  <= ST_IDLE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            wready_q <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    // One beat per edge; the pointer wraps modulo memory size.
                    rdata_q  <= mem_q[ptr_q];
                    rvalid_q <= 1'b1;
                    ptr_q    <= ptr_q + DEPTH'(1);
                    cnt_q    <= cnt_q - BURST_BITS'(1);
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    wready_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = (state_q == ST_IDLE) && !rst_i;
    assign wready_o = wready_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_ram_burst_sync.sv
// Bench for ram_burst_sync: directed scenarios plus randomized bursts checked
// against an array model of memory and the burst timing rules.
module tb_ram_burst_sync;

    localparam int W     = 8;
    localparam int D     = 5;
    localparam int B     = 2;
    localparam int WORDS = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         we;
    logic [D-1:0] addr;
    logic [B-1:0] len;
    logic         gnt;
    logic [W-1:0] wdata;
    logic         wvalid;
    logic         wready;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mm    [WORDS];
    bit           known [WORDS];
    logic [W-1:0] wbuf  [4];

    ram_burst_sync #(.WIDTH(W), .DEPTH(D), .BURST_BITS(B)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .len_i   (len),
        .gnt_o   (gnt),
        .wdata_i (wdata),
        .wvalid_i(wvalid),
        .wready_o(wready),
        .rdata_o (rdata),
        .rvalid_o(rvalid),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write burst from an IDLE cycle; returns in the DONE cycle.
    task automatic do_write(input int a, input int l, input bit rnd, input logic [15:0] pat,
                            output int cyc);
        int idx;
        idx = 0;
        cyc = 0;
        check("w_gnt", 32'(gnt), 1);
        req  = 1'b1;
        we   = 1'b1;
        addr = D'(a);
        len  = B'(l);
        tick();
        req  = 1'b0;
        we   = 1'($urandom);
        addr = D'($urandom);
        len  = B'($urandom);
        while (idx <= l && cyc < 64) begin
            check("w_wready", 32'(wready), 1);
            check("w_busy", 32'(busy), 1);
            check("w_done_low", 32'(done), 0);
            wvalid = rnd ? (($urandom_range(0, 3) != 0) || cyc >= 32) : pat[cyc % 16];
            wdata  = wvalid ? wbuf[idx] : W'($urandom);
            tick();
            cyc++;
            if (wvalid) begin
                mm[(a + idx) % WORDS]    = wbuf[idx];
                known[(a + idx) % WORDS] = 1'b1;
                idx++;
            end
        end
        wvalid = 1'b0;
        check("w_beats", 32'(idx), 32'(l + 1));
        check("w_done", 32'(done), 1);
        check("w_busy_end", 32'(busy), 0);
        check("w_wready_end", 32'(wready), 0);
        check("w_gnt_end", 32'(gnt), 1);
    endtask

    // Issue a read burst from an IDLE cycle; returns in the last RVALID (= DONE) cycle.
    task automatic do_read(input int a, input int l);
        check("r_gnt", 32'(gnt), 1);
        req  = 1'b1;
        we   = 1'b0;
        addr = D'(a);
        len  = B'(l);
        tick();
        req    = 1'b0;
        we     = 1'($urandom);
        addr   = D'($urandom);
        len    = B'($urandom);
        wvalid = 1'($urandom);
        wdata  = W'($urandom);
        check("r_lat_rvalid", 32'(rvalid), 0);
        check("r_lat_busy", 32'(busy), 1);
        for (int k = 0; k <= l; k++) begin
            tick();
            check("r_rvalid", 32'(rvalid), 1);
            if (known[(a + k) % WORDS])
                check("r_data", 32'(rdata), 32'(mm[(a + k) % WORDS]));
            check("r_done", 32'(done), (k == l) ? 1 : 0);
            check("r_busy", 32'(busy), (k == l) ? 0 : 1);
        end
        wvalid = 1'b0;
    endtask

    task automatic idle_chk();
        tick();
        check("idle_rvalid", 32'(rvalid), 0);
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int c;
        rst    = 1'b1;
        req    = 1'b1;
        we     = 1'b1;
        addr   = 5'd3;
        len    = 2'd2;
        wvalid = 1'b1;
        wdata  = 8'h55;
        for (int i = 0; i < WORDS; i++) known[i] = 1'b0;

        // Reset values held with a pending request
        for (int r = 0; r < 3; r++) begin
            #2;
            check("rst_gnt", 32'(gnt), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_wready", 32'(wready), 0);
            check("rst_rvalid", 32'(rvalid), 0);
            check("rst_rdata", 32'(rdata), 0);
            check("rst_done", 32'(done), 0);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_gnt", 32'(gnt), 1);
        req    = 1'b0;
        wvalid = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 0);

        // Populate the whole memory so every later read has a known value
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) wbuf[j] = W'($urandom);
            do_write(i * 4, 3, 1'b0, 16'hFFFF, c);
        end
        idle_chk();

        // Basic burst write then read back
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        do_write(5, 3, 1'b0, 16'hFFFF, c);
        check("wr4_cycles", 32'(c), 4);
        idle_chk();
        do_read(5, 3);
        idle_chk();

        // Address wrap at top of memory
        wbuf[0] = 8'd1; wbuf[1] = 8'd2; wbuf[2] = 8'd3; wbuf[3] = 8'd4;
        do_write(30, 3, 1'b0, 16'hFFFF, c);
        do_read(0, 1);
        do_read(30, 1);
        idle_chk();

        // Write stall: WVALID 1,0,0,1
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'hEE; wbuf[3] = 8'hEE;
        do_write(0, 1, 1'b0, 16'b1001, c);
        check("stall_busy_cycles", 32'(c), 4);
        do_read(0, 3);
        idle_chk();

        // Single beat write with a read accepted in its DONE cycle
        wbuf[0] = 8'h7E;
        do_write(17, 0, 1'b0, 16'hFFFF, c);
        do_read(17, 0);
        idle_chk();

        // Reset in the middle of a write burst
        for (int j = 0; j < 4; j++) wbuf[j] = W'($urandom);
        check("rmw_gnt", 32'(gnt), 1);
        req  = 1'b1;
        we   = 1'b1;
        addr = 5'd8;
        len  = 2'd3;
        tick();
        req    = 1'b0;
        wvalid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            wdata = wbuf[j];
            tick();
            mm[8 + j] = wbuf[j];
        end
        wdata = wbuf[2];
        #1;
        rst = 1'b1;
        #1;
        check("rmw_busy", 32'(busy), 0);
        check("rmw_wready", 32'(wready), 0);
        check("rmw_done", 32'(done), 0);
        check("rmw_gnt", 32'(gnt), 0);
        wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rmw_gnt_after", 32'(gnt), 1);
        do_read(8, 3);
        idle_chk();

        // Randomized bursts, sometimes back-to-back
        for (int it = 0; it < 40; it++) begin
            int a;
            int l;
            a = int'($urandom_range(0, WORDS - 1));
            l = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 4; j++) wbuf[j] = W'($urandom);
                do_write(a, l, 1'b1, 16'h0, c);
            end else begin
                do_read(a, l);
            end
            if ($urandom_range(0, 2) == 0) idle_chk();
        end
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
